// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered execute stage with valid/ready handshake
// Single-cycle logic/arith/compare ops; shifts iterate one bit per cycle.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             shl_q, shl_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             slt;
  logic             start_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_step;

  assign in_ready    = !rst && (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign shamt       = in2[SHW-1:0];
  assign slt         = $signed(in1) < $signed(in2);
  assign start_shift = op[2] && (op[1] || op[0]) && (shamt != '0);

  // fill_q holds the original sign bit for SRA and 0 for SRL
  assign shift_step = shl_q ? {shreg_q[WIDTH-2:0], 1'b0}
                            : {fill_q, shreg_q[WIDTH-1:1]};

  // Zero-amount shifts fall through to the default and pass in1 unchanged
  always_comb begin
    alu_res = in1;
    case (op)
      3'b000:  alu_res = in1 & in2;
      3'b001:  alu_res = in1 | in2;
      3'b010:  alu_res = in1 + in2;
      3'b011:  alu_res = in1 - in2;
      3'b100:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = in1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    fill_d   = fill_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = valid_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (start_shift) begin
            shreg_d = in1;
            cnt_d   = shamt;
            shl_d   = (op == 3'b101);
            fill_d  = (op == 3'b111) && in1[WIDTH-1];
            state_d = S_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shift_step;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d = shift_step;
          zero_d   = (shift_step == '0);
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
      fill_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage
// Directed vectors push expected results; a monitor pops them on each transfer.
module tb_alu_exec_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   w;
  int   lat;
  int   ir;
  int   stray;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every transfer (out_valid && out_ready) must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
        end else begin
          mon_e = sb.pop_front();
          check("sb_result", result, mon_e.res);
          check("sb_zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, mon_e.z});
        end
      end
    end
  end

  // Present an op from posedge+1; returns after its accept edge. waited = stalled cycles.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_res, input bit push, output int waited);
    bit done;
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
    waited   = 0;
    done     = 1'b0;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back(exp_t'{res: exp_res, z: (exp_res == '0)});
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  // Latency counted in edges including the accept edge; also counts in_ready highs while waiting
  task automatic wait_out(output int l, output int ir_hi);
    bit seen;
    l     = 1;
    ir_hi = 0;
    seen  = 1'b0;
    while (!seen && l <= 100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        if (in_ready) ir_hi++;
        l++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
    int wt, l, irh;
    send(o, a, b, exp_res, 1'b1, wt);
    in_valid = 1'b0;
    wait_out(l, irh);
    check({name, "_latency"}, l, exp_lat);
    check({name, "_in_ready_busy"}, irh, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'b000;
    in1       = '0;
    in2       = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_result", result, 0);
    check("rst_zero", {31'b0, zero}, 1);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    // Back-to-back AND then OR at full throughput
    send(3'b000, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b1, w);
    check("and_wait", w, 0);
    send(3'b001, 32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b1, w);
    check("or_wait", w, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("or_valid", {31'b0, out_valid}, 1);
    @(posedge clk);
    #1;

    run_op("add_wrap", 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run_op("sub", 3'b011, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run_op("slt", 3'b100, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    run_op("slt_false", 3'b100, 32'h1, 32'hFFFFFFFF, 32'h0, 1);
    run_op("sra31", 3'b111, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32);
    run_op("sll0", 3'b101, 32'h1, 32'h20, 32'h1, 1);
    run_op("sll4", 3'b101, 32'h1, 32'h24, 32'h10, 5);
    run_op("srl4", 3'b110, 32'hF0000000, 32'd4, 32'h0F000000, 5);
    run_op("sra4", 3'b111, 32'h80000000, 32'd4, 32'hF8000000, 5);

    // Back-pressure: result held while a second op waits on in_valid
    out_ready = 1'b0;
    send(3'b010, 32'd3, 32'd4, 32'd7, 1'b1, w);
    in_valid = 1'b1;
    op       = 3'b000;
    in1      = 32'hFF;
    in2      = 32'h0F;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 1);
      check("hold_result", result, 32'd7);
      check("hold_in_ready", {31'b0, in_ready}, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'b000, 32'hFF, 32'h0F, 32'h0F, 1'b1, w);
    check("release_wait", w, 0);
    in_valid = 1'b0;
    wait_out(lat, ir);
    check("release_latency", lat, 1);

    // Reset in the middle of a shift aborts it
    send(3'b110, 32'h80000000, 32'd20, 32'h0, 1'b0, w);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'b0, out_valid}, 0);
    check("abort_result", result, 0);
    check("abort_zero", {31'b0, zero}, 1);
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_completion", stray, 0);
    @(posedge clk);
    #1;
    run_op("or_after_rst", 3'b001, 32'h1, 32'h2, 32'h3, 1);

    repeat (20) begin
      if (sb.size() != 0) @(posedge clk);
    end
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
